// File: rtl/sram_port_scheduler.sv
// ---------------------------------------------------------------------------
// sram_port_scheduler
//   Owns the single-port T-sequence SRAM and shares it between the host
//   loader (fills T from address 0), the PE read stream (consumes T in order,
//   wrapping at the end of T) and the PE spill stream (rewrites words in place
//   behind the read stream). At most one SRAM access is issued per cycle.
//   The 1-cycle SRAM read latency is hidden behind a 2-entry prefetch FIFO.
//
// Ports
//   clk, rst_n                      clock / asynchronous active-low reset
//   i_load_start                    begin a load from address 0 (IDLE only)
//   i_load_valid/_data/_last        loader word stream
//   o_load_ready                    loader word accepted this cycle
//   i_run                           stream mode enable level
//   i_rd_req, o_rd_valid, o_rd_data prefetch FIFO pop interface
//   i_wr_valid, i_wr_data           spill word
//   o_wr_ready                      spill word written this cycle
//   o_sram_cen/_wen/_addr/_d        SRAM macro controls (cen/wen active low)
//   i_sram_q                        SRAM read data, one cycle after issue
//   o_busy                          high in LOAD and FLUSH
//   o_t_size                        number of T words loaded
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sram_port_scheduler #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load_start,
   input  logic              i_load_valid,
   input  logic [DATA_W-1:0] i_load_data,
   input  logic              i_load_last,
   output logic              o_load_ready,
   input  logic              i_run,
   input  logic              i_rd_req,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   input  logic              i_wr_valid,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   output logic              o_sram_cen,
   output logic              o_sram_wen,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_d,
   input  logic [DATA_W-1:0] i_sram_q,
   output logic              o_busy,
   output logic [ADDR_W:0]   o_t_size
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH} state_t;

   localparam logic [ADDR_W:0]   DEPTH_M1 = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0]   ONE_T    = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ONE_P    = ADDR_W'(1);

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W:0]   r_t_size;
   logic [ADDR_W:0]   r_lag;          // reads issued minus spill writes
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic              r_inflight;     // read issued last cycle, q valid now
   logic              r_last_win_rd;  // winner of the most recent conflict
   logic [DATA_W-1:0] r_fifo [0:1];
   logic              r_fifo_rp;
   logic              r_fifo_wp;
   logic [1:0]        r_fifo_cnt;

   logic              w_run_act;
   logic              w_pop;
   logic [2:0]        w_occ;
   logic              w_rd_elig;
   logic              w_wr_elig;
   logic              w_rd_gnt;
   logic              w_wr_gnt;
   logic              w_load_acc;
   logic              w_load_end;
   logic              w_fifo_clr;
   logic              w_rd_wrap;
   logic              w_wr_wrap;
   logic              w_run_entry;

   assign w_run_act  = (r_state == S_RUN) && i_run;
   assign w_pop      = i_rd_req && (r_fifo_cnt != 2'd0);
   assign w_occ      = {1'b0, r_fifo_cnt} + {2'b00, r_inflight};
   // A pop this cycle frees a slot before the new read lands, so it counts
   // as credit; without it streaming would stall every other cycle.
   assign w_rd_elig  = w_run_act && (r_lag < r_t_size) &&
                       (w_pop ? (w_occ < 3'd3) : (w_occ < 3'd2));
   // Only words the read stream has already fetched may be overwritten.
   assign w_wr_elig  = w_run_act && i_wr_valid && (r_lag != '0);
   assign w_rd_gnt   = w_rd_elig && (!w_wr_elig || !r_last_win_rd);
   assign w_wr_gnt   = w_wr_elig && !w_rd_gnt;
   assign w_load_acc = (r_state == S_LOAD) && i_load_valid;
   assign w_load_end = w_load_acc && (i_load_last || (r_t_size == DEPTH_M1));
   assign w_fifo_clr = (r_state == S_FLUSH) && !r_inflight;
   assign w_rd_wrap  = (({1'b0, r_rd_ptr} + ONE_T) == r_t_size);
   assign w_wr_wrap  = (({1'b0, r_wr_ptr} + ONE_T) == r_t_size);
   assign w_run_entry = (r_state == S_IDLE) && (w_state_next == S_RUN);

   assign o_rd_valid = (r_fifo_cnt != 2'd0);
   assign o_rd_data  = r_fifo[r_fifo_rp];
   assign o_busy     = (r_state == S_LOAD) || (r_state == S_FLUSH);
   assign o_t_size   = r_t_size;

   // SRAM port mux: loader, stream read or spill write, never two at once.
   always_comb begin
      o_sram_cen   = 1'b1;
      o_sram_wen   = 1'b1;
      o_sram_addr  = '0;
      o_sram_d     = '0;
      o_load_ready = 1'b0;
      o_wr_ready   = 1'b0;
      if (w_load_acc) begin
         o_sram_cen   = 1'b0;
         o_sram_wen   = 1'b0;
         o_sram_addr  = r_t_size[ADDR_W-1:0];
         o_sram_d     = i_load_data;
         o_load_ready = 1'b1;
      end else if (w_rd_gnt) begin
         o_sram_cen   = 1'b0;
         o_sram_addr  = r_rd_ptr;
      end else if (w_wr_gnt) begin
         o_sram_cen   = 1'b0;
         o_sram_wen   = 1'b0;
         o_sram_addr  = r_wr_ptr;
         o_sram_d     = i_wr_data;
         o_wr_ready   = 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_load_start)
               w_state_next = S_LOAD;
            else if (i_run && (r_t_size != '0))
               w_state_next = S_RUN;
         end
         S_LOAD:  if (w_load_end) w_state_next = S_IDLE;
         S_RUN:   if (!i_run)     w_state_next = S_FLUSH;
         S_FLUSH: if (!r_inflight) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Load pointer and T size are the same counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_t_size <= '0;
      end else if ((r_state == S_IDLE) && i_load_start) begin
         r_t_size <= '0;
      end else if (w_load_acc) begin
         r_t_size <= r_t_size + ONE_T;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_lag         <= '0;
         r_last_win_rd <= 1'b0;
         r_inflight    <= 1'b0;
      end else begin
         r_inflight <= w_rd_gnt;
         if (w_run_entry) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_lag         <= '0;
            // Pretend the write won last so the first conflict goes to the read.
            r_last_win_rd <= 1'b0;
         end else begin
            if (w_rd_elig && w_wr_elig)
               r_last_win_rd <= w_rd_gnt;
            if (w_rd_gnt) begin
               r_rd_ptr <= w_rd_wrap ? '0 : (r_rd_ptr + ONE_P);
               r_lag    <= r_lag + ONE_T;
            end else if (w_wr_gnt) begin
               r_wr_ptr <= w_wr_wrap ? '0 : (r_wr_ptr + ONE_P);
               r_lag    <= r_lag - ONE_T;
            end
         end
      end
   end

   // Prefetch FIFO: SRAM q is captured the cycle after a read grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fifo[0]  <= '0;
         r_fifo[1]  <= '0;
         r_fifo_rp  <= 1'b0;
         r_fifo_wp  <= 1'b0;
         r_fifo_cnt <= 2'd0;
      end else if (w_fifo_clr || w_run_entry) begin
         r_fifo_rp  <= 1'b0;
         r_fifo_wp  <= 1'b0;
         r_fifo_cnt <= 2'd0;
      end else begin
         if (r_inflight) begin
            r_fifo[r_fifo_wp] <= i_sram_q;
            r_fifo_wp         <= ~r_fifo_wp;
         end
         if (w_pop)
            r_fifo_rp <= ~r_fifo_rp;
         if (r_inflight && !w_pop)
            r_fifo_cnt <= r_fifo_cnt + 2'd1;
         else if (!r_inflight && w_pop)
            r_fifo_cnt <= r_fifo_cnt - 2'd1;
      end
   end

endmodule

// File: tb/tb_sram_port_scheduler.sv
`timescale 1ns/1ps
module tb_sram_port_scheduler;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 512;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_load_start = 1'b0;
   logic              i_load_valid = 1'b0;
   logic [DATA_W-1:0] i_load_data = '0;
   logic              i_load_last = 1'b0;
   logic              o_load_ready;
   logic              i_run = 1'b0;
   logic              i_rd_req = 1'b0;
   logic              o_rd_valid;
   logic [DATA_W-1:0] o_rd_data;
   logic              i_wr_valid = 1'b0;
   logic [DATA_W-1:0] i_wr_data = '0;
   logic              o_wr_ready;
   logic              o_sram_cen;
   logic              o_sram_wen;
   logic [ADDR_W-1:0] o_sram_addr;
   logic [DATA_W-1:0] o_sram_d;
   logic [DATA_W-1:0] i_sram_q = '0;
   logic              o_busy;
   logic [ADDR_W:0]   o_t_size;

   int n_checks = 0;
   int n_errors = 0;

   sram_port_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_load_start(i_load_start), .i_load_valid(i_load_valid),
      .i_load_data(i_load_data), .i_load_last(i_load_last),
      .o_load_ready(o_load_ready),
      .i_run(i_run), .i_rd_req(i_rd_req),
      .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
      .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
      .o_sram_cen(o_sram_cen), .o_sram_wen(o_sram_wen),
      .o_sram_addr(o_sram_addr), .o_sram_d(o_sram_d), .i_sram_q(i_sram_q),
      .o_busy(o_busy), .o_t_size(o_t_size)
   );

   always #5 clk = ~clk;

   // SRAM macro model plus access log (read = addr, write = 1000 + addr).
   logic [DATA_W-1:0] mem [0:DEPTH-1];
   int n_sram_wr = 0;
   int glog [$];
   always @(posedge clk) begin
      if (!o_sram_cen) begin
         if (!o_sram_wen) begin
            mem[o_sram_addr] <= o_sram_d;
            n_sram_wr = n_sram_wr + 1;
            glog.push_back(1000 + int'(o_sram_addr));
         end else begin
            i_sram_q <= mem[o_sram_addr];
            glog.push_back(int'(o_sram_addr));
         end
      end
   end

   int busy_total = 0;
   always @(negedge clk) if (o_busy) busy_total = busy_total + 1;

   logic ready_q [$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("check %s: 0x%0h ok", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int n, input logic [DATA_W-1:0] base, input bit use_last);
      ready_q.delete();
      i_load_start = 1'b1;
      tick();
      i_load_start = 1'b0;
      for (int k = 0; k < n; k++) begin
         i_load_valid = 1'b1;
         i_load_data  = base + DATA_W'(k);
         i_load_last  = use_last && (k == n - 1);
         @(negedge clk);
         ready_q.push_back(o_load_ready);
         tick();
      end
      i_load_valid = 1'b0;
      i_load_last  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, w0, g0, rcnt, wcount, ng;
      logic sampled_ready;
      logic [DATA_W-1:0] pops [$];
      int exp_v [0:8];
      int exp_g [0:11];
      logic [DATA_W-1:0] exp_p [0:6];

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_cen", o_sram_cen, 1);
      check_eq("rst_wen", o_sram_wen, 1);
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_tsize", o_t_size, 0);
      check_eq("rst_rd_valid", o_rd_valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // ---------------- load 5 words ----------------
      b0 = busy_total; w0 = n_sram_wr;
      do_load(5, 32'hA0, 1'b1);
      @(negedge clk);
      check_eq("load_tsize", o_t_size, 5);
      check_eq("load_busy_after", o_busy, 0);
      check_eq("load_busy_cycles", busy_total - b0, 5);
      check_eq("load_writes", n_sram_wr - w0, 5);
      rcnt = 0;
      foreach (ready_q[k]) rcnt += int'(ready_q[k]);
      check_eq("load_ready_cnt", rcnt, 5);
      for (int k = 0; k < 5; k++)
         check_eq($sformatf("load_mem%0d", k), mem[k], 32'hA0 + k);
      tick();

      // ---------------- overflow ----------------
      w0 = n_sram_wr;
      do_load(DEPTH + 3, 32'h1000, 1'b0);
      @(negedge clk);
      check_eq("ovf_writes", n_sram_wr - w0, DEPTH);
      check_eq("ovf_tsize", o_t_size, DEPTH);
      check_eq("ovf_mem_last", mem[DEPTH-1], 32'h1000 + DEPTH - 1);
      for (int k = DEPTH; k < DEPTH + 3; k++)
         check_eq($sformatf("ovf_ready%0d", k), ready_q[k], 0);
      tick();
      do_load(5, 32'hA0, 1'b1);
      @(negedge clk);
      check_eq("reload_tsize", o_t_size, 5);
      tick();

      // ---------------- stream, no spill ----------------
      // c0 = IDLE, c1 = first RUN cycle; lag guard stops reads after 5.
      exp_v = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
      i_run = 1'b1; i_rd_req = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         check_eq($sformatf("strm_valid_c%0d", c), o_rd_valid, exp_v[c]);
         if (exp_v[c] == 1)
            check_eq($sformatf("strm_data_c%0d", c), o_rd_data, 32'hA0 + c - 3);
         if (c == 1) check_eq("strm_first_addr", {o_sram_cen, 23'd0, o_sram_addr}, 0);
         if (c == 6) check_eq("strm_lag_guard_cen", o_sram_cen, 1);
         tick();
      end
      i_run = 1'b0; i_rd_req = 1'b0;
      repeat (3) tick();

      // ---------------- conflict + write guard ----------------
      exp_g = '{0, 1, 1000, 2, 1001, 3, 1002, 4, 1003, 0, 1004, 1};
      exp_p = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hB0, 32'hB1};
      g0 = glog.size();
      wcount = 0;
      i_run = 1'b1; i_rd_req = 1'b1; i_wr_valid = 1'b1; i_wr_data = 32'hB0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c == 1 || c == 2)
            check_eq($sformatf("wr_guard_c%0d", c), o_wr_ready, 0);
         if (c == 3) check_eq("wr_first_grant", o_wr_ready, 1);
         sampled_ready = o_wr_ready;
         if (o_rd_valid && i_rd_req) pops.push_back(o_rd_data);
         tick();
         if (sampled_ready) begin
            wcount++;
            i_wr_data = 32'hB0 + DATA_W'(wcount);
         end
      end
      i_run = 1'b0; i_rd_req = 1'b0; i_wr_valid = 1'b0;
      ng = glog.size() - g0;
      check_eq("conf_grant_cnt_ok", (ng >= 12), 1);
      for (int k = 0; k < 12; k++)
         check_eq($sformatf("conf_grant%0d", k), (k < ng) ? glog[g0 + k] : -1, exp_g[k]);
      check_eq("conf_pop_cnt_ok", (pops.size() >= 7), 1);
      for (int k = 0; k < 7; k++)
         check_eq($sformatf("conf_pop%0d", k), (k < pops.size()) ? pops[k] : 32'hDEAD, exp_p[k]);
      repeat (4) tick();

      // ---------------- flush with read in flight ----------------
      i_run = 1'b1;
      tick();           // first RUN cycle: read issued
      tick();           // read in flight
      i_run = 1'b0;
      @(negedge clk);
      check_eq("flush_no_grant", o_sram_cen, 1);
      tick();
      @(negedge clk);
      check_eq("flush_busy", o_busy, 1);
      check_eq("flush_no_wr_ready", o_wr_ready, 0);
      tick();
      @(negedge clk);
      check_eq("flush_rd_valid", o_rd_valid, 0);
      check_eq("flush_idle_busy", o_busy, 0);
      check_eq("flush_tsize_kept", o_t_size, 5);
      tick();

      // ---------------- async reset mid-LOAD ----------------
      i_load_start = 1'b1;
      tick();
      i_load_start = 1'b0;
      i_load_valid = 1'b1; i_load_data = 32'hC0;
      @(negedge clk);
      check_eq("mid_load_cen", o_sram_cen, 0);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_cen", o_sram_cen, 1);
      check_eq("arst_tsize", o_t_size, 0);
      check_eq("arst_ready", o_load_ready, 0);
      check_eq("arst_busy", o_busy, 0);
      i_load_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // ---------------- run with empty T stays idle ----------------
      i_run = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq($sformatf("empty_run_cen_c%0d", c), o_sram_cen, 1);
         tick();
      end
      i_run = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
